enable_pulse_gen: RTL and testbench

ENABLE_PULSE_GEN -- requirements
Module: enable_pulse_gen

---
 rtl/enable_pulse_gen_if.sv | 26 ++
 rtl/enable_pulse_gen.sv | 133 +++++++++++++
 tb/tb_enable_pulse_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/enable_pulse_gen_if.sv
// Control and status bundle between a rate-select / start / stop controller
// and the enable pulse generator. The controller drives the rate and the
// start/stop levels and receives the enable pulse and the run indication.
interface enable_pulse_gen_if;
    logic [1:0] speed;
    logic       start;
    logic       stop;
    logic       tick;
    logic       running;

    modport master (
        output speed,
        output start,
        output stop,
        input  tick,
        input  running
    );

    modport slave (
        input  speed,
        input  start,
        input  stop,
        output tick,
        output running
    );
endinterface

// File: rtl/enable_pulse_gen.sv
// Enable pulse generator. Produces a one-cycle tick every D clocks while
// running, where D is chosen by the speed input (1, BASE_DIV, 2*BASE_DIV or
// 4*BASE_DIV). Start/stop are level inputs whose rising edges start, pause
// and resume the divider. Pausing freezes the countdown so that a resume
// continues exactly where it left off. All outputs are registered.
module enable_pulse_gen #(
    parameter int BASE_DIV = 50_000_000,
    parameter int CNT_W    = 28
) (
    input  logic          clock,
    input  logic          reset,
    enable_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Reload values are D-1 for each rate; a count of zero means the tick is
    // due on the current edge, so the slowest rate needs 4*BASE_DIV-1.
    localparam logic [CNT_W-1:0] RELOAD_FAST = '0;
    localparam logic [CNT_W-1:0] RELOAD_X1   = CNT_W'(BASE_DIV - 1);
    localparam logic [CNT_W-1:0] RELOAD_X2   = CNT_W'(2 * BASE_DIV - 1);
    localparam logic [CNT_W-1:0] RELOAD_X4   = CNT_W'(4 * BASE_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             tick_reg;
    logic             tick_next;
    logic             running_reg;
    logic             start_d;
    logic             stop_d;

    logic             start_edge;
    logic             stop_edge;
    logic [CNT_W-1:0] reload_value;
    logic [CNT_W-1:0] count_advanced;
    logic             tick_advanced;

    // A held level yields a single edge: high now and low at the previous edge.
    always_comb begin
        start_edge = bus.start & ~start_d;
        stop_edge  = bus.stop  & ~stop_d;
    end

    // Reload value for the rate currently selected; only consulted on a fresh
    // start or on a tick, so a mid-count speed change waits for the next reload.
    always_comb begin
        reload_value = RELOAD_FAST;
        case (bus.speed)
            2'b00:   reload_value = RELOAD_FAST;
            2'b01:   reload_value = RELOAD_X1;
            2'b10:   reload_value = RELOAD_X2;
            2'b11:   reload_value = RELOAD_X4;
            default: reload_value = RELOAD_FAST;
        endcase
    end

    // One running step of the divider: tick and reload at zero, otherwise count down.
    always_comb begin
        count_advanced = count;
        tick_advanced  = 1'b0;
        if (count == '0) begin
            tick_advanced  = 1'b1;
            count_advanced = reload_value;
        end else begin
            count_advanced = count - COUNT_ONE;
        end
    end

    // Next-state logic; a stop edge always wins over a simultaneous start edge.
    always_comb begin
        state_next = state;
        count_next = count;
        tick_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge && !stop_edge) begin
                    state_next = RUN;
                    count_next = reload_value;
                end
            end
            RUN: begin
                if (stop_edge) begin
                    state_next = PAUSE;
                end else begin
                    count_next = count_advanced;
                    tick_next  = tick_advanced;
                end
            end
            PAUSE: begin
                if (start_edge && !stop_edge) begin
                    state_next = RUN;
                    count_next = count_advanced;
                    tick_next  = tick_advanced;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // State, counter, outputs and edge-detect history; edge history resets high
    // so a level already asserted at reset release is not taken as a request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
            start_d     <= 1'b1;
            stop_d      <= 1'b1;
        end else begin
            state       <= state_next;
            count       <= count_next;
            tick_reg    <= tick_next;
            running_reg <= (state_next == RUN);
            start_d     <= bus.start;
            stop_d      <= bus.stop;
        end
    end

    assign bus.tick    = tick_reg;
    assign bus.running = running_reg;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Testbench for enable_pulse_gen with BASE_DIV=4, CNT_W=6. Directed scenarios
// followed by randomized start/stop/speed/reset activity, every edge compared
// against a behavioural model that tracks "edges remaining until the next tick".
module tb_enable_pulse_gen;

    localparam int BASE_DIV = 4;
    localparam int CNT_W    = 6;

    logic clock = 1'b0;
    logic reset;

    enable_pulse_gen_if bus ();

    enable_pulse_gen #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

    int    assert_count = 0;
    int    fail_count   = 0;
    int    edge_num     = 0;
    mode_t mode         = M_IDLE;
    int    remaining    = 0;
    bit    exp_tick     = 1'b0;
    bit    exp_running  = 1'b0;
    bit    prev_start   = 1'b1;
    bit    prev_stop    = 1'b1;

    function automatic int divisor(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return BASE_DIV;
            2'b10:   return 2 * BASE_DIV;
            default: return 4 * BASE_DIV;
        endcase
    endfunction

    // One running edge: one fewer edge to wait; when none remain, tick and
    // schedule the next tick a full period away at the currently selected rate.
    task automatic consume_edge();
        remaining = remaining - 1;
        if (remaining == 0) begin
            exp_tick  = 1'b1;
            remaining = divisor(bus.speed);
        end
    endtask

    // Reference behaviour for one rising clock edge, using the inputs as sampled.
    task automatic model_edge();
        bit start_rise;
        bit stop_rise;
        exp_tick = 1'b0;
        if (reset) begin
            mode       = M_IDLE;
            remaining  = 0;
            prev_start = 1'b1;
            prev_stop  = 1'b1;
        end else begin
            start_rise = bus.start && !prev_start;
            stop_rise  = bus.stop && !prev_stop;
            case (mode)
                M_IDLE: begin
                    if (start_rise && !stop_rise) begin
                        mode      = M_RUN;
                        remaining = divisor(bus.speed);
                    end
                end
                M_RUN: begin
                    if (stop_rise) mode = M_PAUSE;
                    else consume_edge();
                end
                default: begin
                    if (start_rise && !stop_rise) begin
                        mode = M_RUN;
                        consume_edge();
                    end
                end
            endcase
            prev_start = bus.start;
            prev_stop  = bus.stop;
        end
        exp_running = (mode == M_RUN);
    endtask

    // Compare both outputs against the model.
    task automatic check_output();
        assert_count++;
        assert (bus.tick === exp_tick) else begin
            fail_count++;
            $error("[TB] FAIL tick at edge %0d: observed %b expected %b", edge_num, bus.tick, exp_tick);
        end
        assert_count++;
        assert (bus.running === exp_running) else begin
            fail_count++;
            $error("[TB] FAIL running at edge %0d: observed %b expected %b", edge_num, bus.running, exp_running);
        end
    endtask

    // Drive inputs on the falling edge, then advance model and check just after the rising edge.
    task automatic apply_stimulus(input logic r, input logic [1:0] s, input logic st, input logic sp);
        @(negedge clock);
        reset     = r;
        bus.speed = s;
        bus.start = st;
        bus.stop  = sp;
        @(posedge clock);
        model_edge();
        #1;
        check_output();
        edge_num++;
    endtask

    // Two reset edges followed by one quiet edge so the edge history is low.
    task automatic reset_block(input logic [1:0] s);
        apply_stimulus(1'b1, s, 1'b0, 1'b0);
        apply_stimulus(1'b1, s, 1'b0, 1'b0);
        apply_stimulus(1'b0, s, 1'b0, 1'b0);
    endtask

    // Directed scenarios followed by randomized activity.
    initial begin
        logic [1:0] rnd_speed;
        logic       rnd_start;
        logic       rnd_stop;
        reset     = 1'b1;
        bus.speed = 2'b00;
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Rate x1: start at edge 10, ticks at 14, 18, 22.
        for (int e = 0; e <= 24; e++)
            apply_stimulus(e < 2, 2'b01, e >= 10, 1'b0);

        // Fastest rate then stop edge.
        reset_block(2'b00);
        for (int e = 0; e <= 15; e++)
            apply_stimulus(1'b0, 2'b00, e >= 5, e >= 12);

        // Slowest rate with pause and resume from the held count.
        reset_block(2'b11);
        for (int e = 0; e <= 48; e++)
            apply_stimulus(1'b0, 2'b11, (e <= 3) || (e >= 20), (e >= 6) && (e <= 8));

        // Speed change mid-count applies only at the next reload.
        reset_block(2'b01);
        for (int e = 0; e <= 14; e++)
            apply_stimulus(1'b0, (e < 2) ? 2'b01 : 2'b10, 1'b1, 1'b0);

        // Simultaneous start and stop from idle, then start held high.
        reset_block(2'b01);
        apply_stimulus(1'b0, 2'b01, 1'b1, 1'b1);
        for (int e = 0; e < 6; e++)
            apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0);

        // Reset one edge before a tick, start held through reset release.
        reset_block(2'b01);
        for (int e = 0; e <= 7; e++)
            apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0);
        apply_stimulus(1'b1, 2'b01, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++)
            apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0);

        // Random rate changes, start/stop toggling and occasional reset.
        reset_block(2'b01);
        rnd_speed = 2'b01;
        rnd_start = 1'b0;
        rnd_stop  = 1'b0;
        for (int e = 0; e < 600; e++) begin
            if ($urandom_range(0, 19) == 0) rnd_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)  rnd_start = ~rnd_start;
            if ($urandom_range(0, 11) == 0) rnd_stop  = ~rnd_stop;
            apply_stimulus($urandom_range(0, 149) == 0, rnd_speed, rnd_start, rnd_stop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
